// File: rtl/key_snapshot_writer_pkg.sv
// Shared constants, FSM state type and word-format helper for the
// controller button snapshot writer.
package key_snapshot_writer_pkg;

  // Board-level defaults: button count, base address and memory geometry.
  localparam int unsigned KEY_NUM      = 16;
  localparam int unsigned KEY_MEM      = 0;
  localparam int unsigned DATA_ADDR_W  = 13;

  // 1 ms debounce sample period at 25.175 MHz; samples needed to accept.
  localparam int unsigned DBNC_TICK    = 25175;
  localparam int unsigned DBNC_SAMPLES = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } ksw_state_e;

  // Memory word: bit0 = stable level, bit1 = pressed-since-last-report.
  function automatic logic [15:0] pack_word(input logic pressed, input logic level);
    return {14'b0, pressed, level};
  endfunction

endpackage

// File: rtl/key_snapshot_writer_button_debouncer.sv
// Single-button synchroniser + sample-count debouncer with rising-edge pulse.
module button_debouncer #(
  parameter int unsigned SAMPLES = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic tick_i,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  logic       sync1_q, sync2_q;
  logic       stable_q, stable_d;
  logic [7:0] cnt_q, cnt_d;
  logic       accept;

  // Two-flop synchroniser for the asynchronous button level.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // On each tick, count disagreeing samples; accept after SAMPLES in a row.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    if (tick_i) begin
      if (sync2_q != stable_q) begin
        if (cnt_q == 8'(SAMPLES - 1)) begin
          accept   = 1'b1;
          stable_d = sync2_q;
          cnt_d    = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 8'd1;
        end
      end else begin
        cnt_d = '0;
      end
    end
    rise_o = accept & sync2_q;
  end

  // Debounce state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/key_snapshot_writer.sv
// Debounces controller buttons and, on each copy_start, writes a frozen
// snapshot (one word per button) into data memory via the copy-mode port.
module key_snapshot_writer
  import key_snapshot_writer_pkg::*;
#(
  parameter int unsigned BUTTON_COUNT     = KEY_NUM,
  parameter int unsigned BUTTON_ADDR      = KEY_MEM,
  parameter int unsigned DATA_ADDR_WIDTH  = DATA_ADDR_W,
  parameter int unsigned DEBOUNCE_TICK    = DBNC_TICK,
  parameter int unsigned DEBOUNCE_SAMPLES = DBNC_SAMPLES
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [15:0]                buttons_in,
  input  logic                       copy_start,
  output logic                       busy,
  output logic                       mem_dout_we,
  output logic [DATA_ADDR_WIDTH-1:0] mem_dout_addr,
  output logic [15:0]                mem_dout
);

  localparam int unsigned PW = (DEBOUNCE_TICK > 1) ? $clog2(DEBOUNCE_TICK) : 1;
  localparam int unsigned IW = (BUTTON_COUNT > 1) ? $clog2(BUTTON_COUNT) : 1;

  logic [PW-1:0]           presc_q, presc_d;
  logic                    tick;
  logic [BUTTON_COUNT-1:0] stable, rise;
  logic [BUTTON_COUNT-1:0] pressed_q, pressed_d;
  logic [BUTTON_COUNT-1:0] snap_level_q, snap_level_d;
  logic [BUTTON_COUNT-1:0] snap_pressed_q, snap_pressed_d;
  logic [IW-1:0]           idx_q, idx_d;
  ksw_state_e              state_q, state_d;
  logic                    we_q, we_d;
  logic                    busy_q, busy_d;
  logic [DATA_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]             dout_q, dout_d;

  // Bits at or above BUTTON_COUNT are intentionally ignored.
  logic unused_buttons;
  assign unused_buttons = ^buttons_in;

  // Shared prescaler producing the debounce sample tick.
  always_comb begin
    tick    = (presc_q == PW'(DEBOUNCE_TICK - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  for (genvar g = 0; g < BUTTON_COUNT; g++) begin : g_btn
    button_debouncer #(
      .SAMPLES (DEBOUNCE_SAMPLES)
    ) u_dbnc (
      .clk      (clk),
      .resetn   (resetn),
      .tick_i   (tick),
      .raw_i    (buttons_in[g]),
      .stable_o (stable[g]),
      .rise_o   (rise[g])
    );
  end

  // Edge latch, burst sequencing and next values for the registered outputs.
  // A rise on the write cycle of the same button is OR-ed in after the clear,
  // so the press survives into the next burst.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    snap_level_d   = snap_level_q;
    snap_pressed_d = snap_pressed_q;
    pressed_d      = pressed_q;

    if (state_q == ST_WRITE) pressed_d[idx_q] = 1'b0;
    pressed_d = pressed_d | rise;

    case (state_q)
      ST_IDLE: begin
        if (copy_start) begin
          snap_level_d   = stable;
          snap_pressed_d = pressed_q;
          idx_d          = '0;
          state_d        = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (idx_q == IW'(BUTTON_COUNT - 1)) state_d = ST_IDLE;
        else                                idx_d   = idx_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    we_d   = (state_d == ST_WRITE);
    busy_d = we_d;
    addr_d = '0;
    dout_d = '0;
    if (we_d) begin
      addr_d = DATA_ADDR_WIDTH'(BUTTON_ADDR) + DATA_ADDR_WIDTH'(idx_d);
      dout_d = pack_word(snap_pressed_d[idx_d], snap_level_d[idx_d]);
    end
  end

  // State, snapshot, edge flags and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      presc_q        <= '0;
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      snap_level_q   <= '0;
      snap_pressed_q <= '0;
      pressed_q      <= '0;
      we_q           <= 1'b0;
      busy_q         <= 1'b0;
      addr_q         <= '0;
      dout_q         <= '0;
    end else begin
      presc_q        <= presc_d;
      state_q        <= state_d;
      idx_q          <= idx_d;
      snap_level_q   <= snap_level_d;
      snap_pressed_q <= snap_pressed_d;
      pressed_q      <= pressed_d;
      we_q           <= we_d;
      busy_q         <= busy_d;
      addr_q         <= addr_d;
      dout_q         <= dout_d;
    end
  end

  assign busy          = busy_q;
  assign mem_dout_we   = we_q;
  assign mem_dout_addr = addr_q;
  assign mem_dout      = dout_q;

endmodule
